// File: rtl/rtc_pkg.sv
// Shared definitions for the BCD real-time clock: field-select codes,
// per-field BCD limits and the load-value validity check.
package rtc_pkg;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HOUR = 2'd2,
    SEL_RSVD = 2'd3
  } field_sel_e;

  localparam logic [7:0] BCD_MAX_SM   = 8'h59;  // seconds and minutes
  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;  // 24-hour format

  // A value is loadable when both nibbles are decimal digits and the
  // packed value does not exceed the field maximum.
  function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max_bcd);
    return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max_bcd);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps from MAX_BCD to 00.
// A load takes priority over counting and suppresses the carry out,
// so a field being written never ripples into the field above it.
module bcd_mod_counter
  import rtc_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = BCD_MAX_SM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] data,
  output logic       carry
);

  logic [7:0] next_inc;

  // Next BCD value when counting: wrap at max, else decimal-adjust the low digit.
  always_comb begin
    next_inc = data + 8'h01;
    if (data == MAX_BCD) begin
      next_inc = 8'h00;
    end else if (data[3:0] == 4'd9) begin
      next_inc = {data[7:4] + 4'd1, 4'd0};
    end
  end

  assign carry = en && !load && (data == MAX_BCD);

  // Field register: load wins over count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= 8'h00;
    end else if (load) begin
      data <= load_val;
    end else if (en) begin
      data <= next_inc;
    end
  end

endmodule

// File: rtl/rtc_bcd_clock.sv
// 24-hour BCD clock: prescales clk to a 10 Hz tick, then counts tenths,
// seconds, minutes and hours with same-cycle carry ripple.
// Optional alarm comparator is built when RTC_ALARM_EN is defined.
// Load semantics: set_en is a single-cycle strobe; a valid value lands in
// the selected field on the next edge, an invalid one pulses set_err.
module rtc_bcd_clock
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic [7:0] set_val,
  output logic [3:0] tenths,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic       sec_pulse,
  output logic       set_err
`ifdef RTC_ALARM_EN
  ,
  input  logic       alarm_set,
  input  logic       alarm_clr,
  output logic       alarm
`endif
);

  localparam int DIV = CLK_HZ / 10;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick10;
  logic          carry_s, carry_m, carry_h;
  logic [7:0]    sel_max;
  logic          set_ok;
  logic          load_sec, load_min, load_hour;
  logic          err_now;

  assign tick10  = run && (cnt == CNT_LAST);
  assign carry_s = tick10 && (tenths == 4'd9);

  // Limit for the field addressed by set_sel.
  always_comb begin
    sel_max = BCD_MAX_SM;
    if (set_sel == SEL_HOUR) begin
      sel_max = BCD_MAX_HOUR;
    end
  end

  assign set_ok    = (set_sel != SEL_RSVD) && bcd_valid(set_val, sel_max);
  assign load_sec  = set_en && set_ok && (set_sel == SEL_SEC);
  assign load_min  = set_en && set_ok && (set_sel == SEL_MIN);
  assign load_hour = set_en && set_ok && (set_sel == SEL_HOUR);

  // Prescaler: holds while paused; a seconds load restarts the current second.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load_sec) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Tenths digit (binary 0..9), cleared together with the prescaler on a seconds load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tenths <= 4'd0;
    end else if (load_sec) begin
      tenths <= 4'd0;
    end else if (tick10) begin
      tenths <= (tenths == 4'd9) ? 4'd0 : tenths + 4'd1;
    end
  end

  bcd_mod_counter #(.MAX_BCD(BCD_MAX_SM)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .en       (carry_s),
    .load     (load_sec),
    .load_val (set_val),
    .data     (sec),
    .carry    (carry_m)
  );

  bcd_mod_counter #(.MAX_BCD(BCD_MAX_SM)) u_min (
    .clk      (clk),
    .reset    (reset),
    .en       (carry_m),
    .load     (load_min),
    .load_val (set_val),
    .data     (min),
    .carry    (carry_h)
  );

  // Hour carry out is unused: 23 -> 00 wraps silently.
  logic carry_day;
  bcd_mod_counter #(.MAX_BCD(BCD_MAX_HOUR)) u_hour (
    .clk      (clk),
    .reset    (reset),
    .en       (carry_h),
    .load     (load_hour),
    .load_val (set_val),
    .data     (hour),
    .carry    (carry_day)
  );

`ifdef RTC_ALARM_EN
  logic [7:0] al_min, al_hour;
  logic       al_ok, match, match_q;

  assign al_ok = set_ok && ((set_sel == SEL_MIN) || (set_sel == SEL_HOUR));
  assign match = (hour == al_hour) && (min == al_min) && (sec == 8'h00) && (tenths == 4'd0);
  assign err_now = (set_en && !set_ok) || (alarm_set && !al_ok);

  // Alarm time register, written with the same validation as a field load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      al_min  <= 8'h00;
      al_hour <= 8'h00;
    end else if (alarm_set && al_ok) begin
      if (set_sel == SEL_MIN) begin
        al_min <= set_val;
      end else begin
        al_hour <= set_val;
      end
    end
  end

  // Alarm fires on the rising edge of a match so that clearing it inside the
  // matching tenth does not re-arm; match_q resets high so that the reset
  // time 00:00:00.0 never counts as an alarm event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= 1'b1;
      alarm   <= 1'b0;
    end else begin
      match_q <= match;
      if (alarm_clr) begin
        alarm <= 1'b0;
      end else if (match && !match_q) begin
        alarm <= 1'b1;
      end
    end
  end
`else
  assign err_now = set_en && !set_ok;
`endif

  // Status strobes: counted seconds change and rejected loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_pulse <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      sec_pulse <= carry_s && !load_sec;
      set_err   <= err_now;
    end
  end

endmodule

// File: tb/tb_rtc_bcd_clock.sv
// Self-checking bench for rtc_bcd_clock with CLK_HZ=100 (10 clocks per tenth).
// A time-of-day model in total tenths predicts each cycle's outputs.
module tb_rtc_bcd_clock;

  localparam int CLK_HZ = 100;
  localparam int DIV    = CLK_HZ / 10;
  localparam int W      = 30;

  logic       clk, reset, run, set_en;
  logic [1:0] set_sel;
  logic [7:0] set_val;
  logic [3:0] tenths;
  logic [7:0] sec, min, hour;
  logic       sec_pulse, set_err;
`ifdef RTC_ALARM_EN
  logic       alarm_set, alarm_clr, alarm;
`endif

  rtc_bcd_clock #(.CLK_HZ(CLK_HZ)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .set_en    (set_en),
    .set_sel   (set_sel),
    .set_val   (set_val),
    .tenths    (tenths),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .sec_pulse (sec_pulse),
    .set_err   (set_err)
`ifdef RTC_ALARM_EN
    ,
    .alarm_set (alarm_set),
    .alarm_clr (alarm_clr),
    .alarm     (alarm)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  int   m_cnt, m_t, m_s, m_m, m_h;
  logic m_sp, m_se;

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic logic [W-1:0] model_word();
    return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), 4'(m_t), m_sp, m_se};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the reference model, in whole-day tenths arithmetic.
  task automatic model_step(input logic r, input logic se, input logic [1:0] sel, input logic [7:0] v);
    int dec, lim, tot, ncnt, nt, ns, nm, nh;
    logic ok, tick;
    dec  = int'(v[7:4]) * 10 + int'(v[3:0]);
    lim  = (sel == 2'd2) ? 23 : 59;
    ok   = se && (sel != 2'd3) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (dec <= lim);
    tick = r && (m_cnt == DIV - 1);
    ncnt = r ? (m_cnt + 1) % DIV : m_cnt;
    tot  = ((m_h * 60 + m_m) * 60 + m_s) * 10 + m_t;
    if (tick) tot = (tot + 1) % 864000;
    nt = tot % 10;
    ns = (tot / 10) % 60;
    nm = (tot / 600) % 60;
    nh = tot / 36000;
    m_sp = tick && (m_t == 9);
    if (ok) begin
      case (sel)
        2'd0: begin nt = 0; ncnt = 0; ns = dec; nm = m_m; nh = m_h; m_sp = 1'b0; end
        2'd1: begin nm = dec; nh = m_h; end
        default: nh = dec;
      endcase
    end
    m_se  = se && !ok;
    m_cnt = ncnt; m_t = nt; m_s = ns; m_m = nm; m_h = nh;
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic se, input logic [1:0] sel, input logic [7:0] v);
    logic [W-1:0] e;
    run = r; set_en = se; set_sel = sel; set_val = v;
    model_step(r, se, sel, v);
    exp_q.push_back(model_word());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("cycle", {hour, min, sec, tenths, sec_pulse, set_err}, e);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 2'd0, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; run = 1'b0; set_en = 1'b0; set_sel = 2'd0; set_val = 8'h00;
`ifdef RTC_ALARM_EN
    alarm_set = 1'b0; alarm_clr = 1'b0;
`endif
    m_cnt = 0; m_t = 0; m_s = 0; m_m = 0; m_h = 0; m_sp = 1'b0; m_se = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {hour, min, sec, tenths, sec_pulse, set_err}, '0);
    reset = 1'b0;

    // Basic counting from reset.
    run_n(10);
    check("tenths_after_10", tenths, 4'd1);
    run_n(89);
    check("sec_before_100", sec, 8'h00);
    run_n(1);
    check("sec_after_100", sec, 8'h01);
    check("sec_pulse_on", sec_pulse, 1'b1);
    run_n(1);
    check("sec_pulse_off", sec_pulse, 1'b0);

    // 23:59:59 rolls to midnight in a single clock.
    cyc(1'b1, 1'b1, 2'd2, 8'h23);
    cyc(1'b1, 1'b1, 2'd1, 8'h59);
    cyc(1'b1, 1'b1, 2'd0, 8'h59);
    check("load_sec_clears_tenths", tenths, 4'd0);
    run_n(99);
    check("before_midnight", {hour, min, sec, tenths}, {8'h23, 8'h59, 8'h59, 4'd9});
    run_n(1);
    check("midnight", {hour, min, sec, tenths}, 28'h0);
    check("midnight_pulse", sec_pulse, 1'b1);

    // Rejected loads while paused: set_err pulses, time unchanged.
    cyc(1'b0, 1'b1, 2'd0, 8'h5A);
    check("err_sec_5a", set_err, 1'b1);
    check("keep_sec_5a", {hour, min, sec, tenths}, 28'h0);
    cyc(1'b0, 1'b1, 2'd1, 8'h60);
    check("err_min_60", set_err, 1'b1);
    check("keep_min_60", {hour, min, sec, tenths}, 28'h0);
    cyc(1'b0, 1'b1, 2'd2, 8'h24);
    check("err_hour_24", set_err, 1'b1);
    check("keep_hour_24", {hour, min, sec, tenths}, 28'h0);
    cyc(1'b0, 1'b1, 2'd3, 8'h12);
    check("err_sel3", set_err, 1'b1);
    check("keep_sel3", {hour, min, sec, tenths}, 28'h0);
    cyc(1'b0, 1'b0, 2'd0, 8'h00);
    check("err_clear", set_err, 1'b0);
    cyc(1'b0, 1'b1, 2'd1, 8'h45);
    check("paused_load_min", min, 8'h45);
    check("paused_load_ok", set_err, 1'b0);

    // Minute load in the very cycle seconds wrap: load wins.
    cyc(1'b1, 1'b1, 2'd0, 8'h59);
    run_n(99);
    cyc(1'b1, 1'b1, 2'd1, 8'h30);
    check("wrap_load_min", min, 8'h30);
    check("wrap_load_sec", sec, 8'h00);
    check("wrap_load_hour", hour, 8'h00);

    // Pause mid-prescale; the remaining count resumes.
    run_n(5);
    for (int i = 0; i < 1000; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00);
    check("frozen_tenths", tenths, 4'd0);
    run_n(4);
    check("no_early_tick", tenths, 4'd0);
    run_n(1);
    check("resume_tick", tenths, 4'd1);

`ifdef RTC_ALARM_EN
    // Alarm at 07:00, approached from 06:59:59.
    alarm_clr = 1'b1; cyc(1'b1, 1'b0, 2'd0, 8'h00); alarm_clr = 1'b0;
    alarm_set = 1'b1; cyc(1'b1, 1'b0, 2'd1, 8'h00);
    cyc(1'b1, 1'b0, 2'd2, 8'h07); alarm_set = 1'b0;
    cyc(1'b1, 1'b1, 2'd2, 8'h06);
    cyc(1'b1, 1'b1, 2'd1, 8'h59);
    cyc(1'b1, 1'b1, 2'd0, 8'h59);
    run_n(99);
    check("alarm_quiet", alarm, 1'b0);
    run_n(1);
    check("alarm_time", {hour, min, sec, tenths}, {8'h07, 8'h00, 8'h00, 4'd0});
    run_n(1);
    check("alarm_fire", alarm, 1'b1);
    alarm_clr = 1'b1; cyc(1'b1, 1'b0, 2'd0, 8'h00); alarm_clr = 1'b0;
    check("alarm_cleared", alarm, 1'b0);
    run_n(50);
    check("alarm_stays_clear", alarm, 1'b0);
`endif

    // Randomised run/pause and loads, checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      logic r, se;
      logic [1:0] sel;
      logic [7:0] v;
      r   = ($urandom_range(0, 9) != 0);
      se  = ($urandom_range(0, 19) == 0);
      sel = 2'($urandom_range(0, 3));
      v   = ($urandom_range(0, 1) == 0) ? to_bcd($urandom_range(0, 59)) : 8'($urandom_range(0, 255));
      cyc(r, se, sel, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
